usb_packet_receiver: RTL and testbench

Serial USB-style packet receiver. Recovers bit timing from the differential d_plus/d_minus line and decodes transitions into bits. Captures the SYNC, PID, CRC and data fields of token, data and handshake packets into parallel output registers. Sits between the bus pins and the packet-processing logic of the USB encryptor.

---
 rtl/usb_packet_receiver.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_usb_packet_receiver.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_packet_receiver.sv
// usb_packet_receiver
// Recovers bit timing from the D+/D- pair and decodes line transitions into bits.
// A transition is a 1 and no transition is a 0. Bit unstuffing is not done.
// The SYNC, PID, CRC5, CRC16 and data fields are shifted in MSB first. Each field
// is loaded into its output register when its last bit arrives.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | bus idle (J); the first K sample is SYNC bit 7
// S_SYNC   | collecting the remaining 7 SYNC bits
// S_PID    | collecting 8 PID bits, then branch on PID type and check
// S_CRC5   | collecting 5 token CRC bits
// S_CRC16  | collecting 16 data-packet CRC bits
// S_DATA   | collecting 64 payload bits
// S_EOP    | ignoring bits until an SE0 sample
// S_EOP_J  | SE0 seen (EOP or abort); waiting for a J sample to go idle

module usb_packet_receiver #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_plus,
    input  logic        d_minus,
    output logic [7:0]  rcv_sync,
    output logic [7:0]  rcv_pid,
    output logic [4:0]  rcv_crc5,
    output logic [15:0] rcv_crc16,
    output logic [63:0] rcv_data
);

    // The phase timer counts down from CLKS_PER_BIT-1. Down-count value CLKS_PER_BIT/2
    // is the same moment as up-count value CLKS_PER_BIT/2-1 after a line edge.
    localparam int PW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PH_RELOAD = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_SAMPLE = PW'(CLKS_PER_BIT / 2);

    // Bits-left values are loaded as (remaining bits - 1); the field completes at 0.
    // The first SYNC bit is consumed in IDLE, so 7 SYNC bits remain after it.
    localparam logic [5:0] BL_SYNC  = 6'd6;
    localparam logic [5:0] BL_PID   = 6'd7;
    localparam logic [5:0] BL_CRC5  = 6'd4;
    localparam logic [5:0] BL_CRC16 = 6'd15;
    localparam logic [5:0] BL_DATA  = 6'd63;

    typedef enum logic [1:0] {
        LINE_J   = 2'd0,
        LINE_K   = 2'd1,
        LINE_SE0 = 2'd2
    } line_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_PID   = 3'd2,
        S_CRC5  = 3'd3,
        S_CRC16 = 3'd4,
        S_DATA  = 3'd5,
        S_EOP   = 3'd6,
        S_EOP_J = 3'd7
    } state_t;

    logic          r_dp_meta;
    logic          r_dp_sync;
    logic          r_dm_meta;
    logic          r_dm_sync;

    line_t         w_line;
    line_t         r_line_prev;
    line_t         r_ref;
    line_t         w_ref;
    logic          w_edge;
    logic          w_sample;
    logic          w_bit;
    logic [PW-1:0] r_phase;

    logic [62:0]   r_shift;
    logic [63:0]   w_field;
    logic          w_pid_ok;
    logic [5:0]    r_bits_left;
    logic [5:0]    w_bits_value;
    logic          w_bits_load;
    logic          w_shift_en;

    logic          w_load_sync;
    logic          w_load_pid;
    logic          w_load_crc5;
    logic          w_load_crc16;
    logic          w_load_data;

    state_t        r_state;
    state_t        w_state_next;

    // Two-flop synchronizers on both bus pins, parked at J in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_meta <= 1'b1;
            r_dp_sync <= 1'b1;
            r_dm_meta <= 1'b0;
            r_dm_sync <= 1'b0;
        end else begin
            r_dp_meta <= d_plus;
            r_dp_sync <= r_dp_meta;
            r_dm_meta <= d_minus;
            r_dm_sync <= r_dm_meta;
        end
    end

    // Classify the synchronized pair; (1,1) is treated as J
    always_comb begin
        w_line = LINE_J;
        if (!r_dp_sync && !r_dm_sync) begin
            w_line = LINE_SE0;
        end else if (!r_dp_sync && r_dm_sync) begin
            w_line = LINE_K;
        end
    end

    // An edge in the sample cycle suppresses that sample and re-phases the timer
    assign w_edge   = (w_line != r_line_prev);
    assign w_sample = !w_edge && (r_phase == PH_SAMPLE);

    // In IDLE the reference is always J, so the first K decodes as a 1
    assign w_ref    = (r_state == S_IDLE) ? LINE_J : r_ref;
    assign w_bit    = (w_line != w_ref);
    assign w_field  = {r_shift, w_bit};
    assign w_pid_ok = (w_field[3:0] == ~w_field[7:4]);

    // Bit-phase timer: reload on every line change, otherwise count down and wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_prev <= LINE_J;
            r_phase     <= PH_RELOAD;
        end else begin
            r_line_prev <= w_line;
            if (w_edge || (r_phase == '0)) begin
                r_phase <= PH_RELOAD;
            end else begin
                r_phase <= r_phase - PW'(1);
            end
        end
    end

    // Remember the line state of the last sampled bit for transition decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref <= LINE_J;
        end else if (w_sample) begin
            r_ref <= w_line;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state, field load strobes and bit-counter reloads
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_bits_load  = 1'b0;
        w_bits_value = 6'd0;
        w_load_sync  = 1'b0;
        w_load_pid   = 1'b0;
        w_load_crc5  = 1'b0;
        w_load_crc16 = 1'b0;
        w_load_data  = 1'b0;

        if (w_sample) begin
            if ((r_state != S_IDLE) && (w_line == LINE_SE0)) begin
                // SE0 ends the packet and discards any partial field
                w_state_next = S_EOP_J;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_line == LINE_K) begin
                            w_shift_en   = 1'b1;
                            w_bits_load  = 1'b1;
                            w_bits_value = BL_SYNC;
                            w_state_next = S_SYNC;
                        end
                    end
                    S_SYNC: begin
                        w_shift_en = 1'b1;
                        if (r_bits_left == 6'd0) begin
                            w_load_sync  = 1'b1;
                            w_bits_load  = 1'b1;
                            w_bits_value = BL_PID;
                            w_state_next = S_PID;
                        end
                    end
                    S_PID: begin
                        w_shift_en = 1'b1;
                        if (r_bits_left == 6'd0) begin
                            w_load_pid   = 1'b1;
                            w_state_next = S_EOP;
                            if (w_pid_ok && (w_field[5:4] == 2'b01)) begin
                                w_bits_load  = 1'b1;
                                w_bits_value = BL_CRC5;
                                w_state_next = S_CRC5;
                            end else if (w_pid_ok && (w_field[5:4] == 2'b11)) begin
                                w_bits_load  = 1'b1;
                                w_bits_value = BL_CRC16;
                                w_state_next = S_CRC16;
                            end
                        end
                    end
                    S_CRC5: begin
                        w_shift_en = 1'b1;
                        if (r_bits_left == 6'd0) begin
                            w_load_crc5  = 1'b1;
                            w_state_next = S_EOP;
                        end
                    end
                    S_CRC16: begin
                        w_shift_en = 1'b1;
                        if (r_bits_left == 6'd0) begin
                            w_load_crc16 = 1'b1;
                            w_bits_load  = 1'b1;
                            w_bits_value = BL_DATA;
                            w_state_next = S_DATA;
                        end
                    end
                    S_DATA: begin
                        w_shift_en = 1'b1;
                        if (r_bits_left == 6'd0) begin
                            w_load_data  = 1'b1;
                            w_state_next = S_EOP;
                        end
                    end
                    S_EOP: begin
                    end
                    S_EOP_J: begin
                        if (w_line == LINE_J) begin
                            w_state_next = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Field shift register and bits-left down-counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_bits_left <= 6'd0;
        end else begin
            if (w_shift_en) begin
                r_shift <= w_field[62:0];
            end
            if (w_bits_load) begin
                r_bits_left <= w_bits_value;
            end else if (w_shift_en && (r_bits_left != 6'd0)) begin
                r_bits_left <= r_bits_left - 6'd1;
            end
        end
    end

    // Output registers; each one holds until its own field completes again
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcv_sync  <= '0;
            rcv_pid   <= '0;
            rcv_crc5  <= '0;
            rcv_crc16 <= '0;
            rcv_data  <= '0;
        end else begin
            if (w_load_sync) begin
                rcv_sync <= w_field[7:0];
            end
            if (w_load_pid) begin
                rcv_pid <= w_field[7:0];
            end
            if (w_load_crc5) begin
                rcv_crc5 <= w_field[4:0];
            end
            if (w_load_crc16) begin
                rcv_crc16 <= w_field[15:0];
            end
            if (w_load_data) begin
                rcv_data <= w_field;
            end
        end
    end

endmodule

// File: tb/tb_usb_packet_receiver.sv
// Testbench for usb_packet_receiver: drives encoded packets on D+/D-. Expected
// register contents are pushed to a scoreboard when a packet is sent. They are
// popped and compared once the packet's EOP has been driven.

module tb_usb_packet_receiver;

    localparam int CPB = 8;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        d_plus  = 1'b1;
    logic        d_minus = 1'b0;
    logic [7:0]  rcv_sync;
    logic [7:0]  rcv_pid;
    logic [4:0]  rcv_crc5;
    logic [15:0] rcv_crc16;
    logic [63:0] rcv_data;

    usb_packet_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_plus    (d_plus),
        .d_minus   (d_minus),
        .rcv_sync  (rcv_sync),
        .rcv_pid   (rcv_pid),
        .rcv_crc5  (rcv_crc5),
        .rcv_crc16 (rcv_crc16),
        .rcv_data  (rcv_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  sync;
        logic [7:0]  pid;
        logic [4:0]  crc5;
        logic [15:0] crc16;
        logic [63:0] data;
    } rec_t;

    rec_t sb[$];
    rec_t model;
    rec_t exp_r;
    rec_t act;
    logic cur_k;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic rec_t outs();
        rec_t r;
        r = {rcv_sync, rcv_pid, rcv_crc5, rcv_crc16, rcv_data};
        return r;
    endfunction

    // Expected registers after a packet: SYNC and PID always load; a well-formed
    // token loads CRC5; a well-formed data packet loads CRC16, and loads the
    // payload only if all 64 payload bits arrived before SE0.
    function automatic rec_t predict(input rec_t prev, input logic [7:0] pid,
                                     input logic [4:0] c5, input logic [15:0] c16,
                                     input logic [63:0] d, input logic data_done);
        rec_t r;
        r      = prev;
        r.sync = 8'h80;
        r.pid  = pid;
        if (pid[3:0] == ~pid[7:4]) begin
            if (pid[5:4] == 2'b01) begin
                r.crc5 = c5;
            end else if (pid[5:4] == 2'b11) begin
                r.crc16 = c16;
                if (data_done) r.data = d;
            end
        end
        return r;
    endfunction

    task put_line(input logic se0);
        if (se0)        {d_plus, d_minus} = 2'b00;
        else if (cur_k) {d_plus, d_minus} = 2'b01;
        else            {d_plus, d_minus} = 2'b10;
    endtask

    task drive_bit(input logic b);
        if (b) cur_k = ~cur_k;
        put_line(1'b0);
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task send_field(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive_bit(v[i]);
    endtask

    task send_eop;
        put_line(1'b1);
        repeat (CPB) @(posedge clk);
        #1;
        cur_k = 1'b0;
        put_line(1'b0);
        repeat (3 * CPB) @(posedge clk);
        #1;
    endtask

    task test_reset;
        rst = 1'b1;
        cur_k = 1'b0;
        put_line(1'b0);
        model = '0;
        sb.push_back(model);
        repeat (3) @(posedge clk);
        #1;
        act = outs();
        n_vec++;
        if (act !== model) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", act, model);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            act = outs();
            n_vec++;
            if (act !== model) begin
                n_err++;
                $display("FAIL idle_no_load cycle %0d: got %h expected %h", i, act, model);
            end
        end
        exp_r = sb.pop_front();
        act = outs();
        n_vec++;
        if (act !== exp_r) begin
            n_err++;
            $display("FAIL idle_final: got %h expected %h", act, exp_r);
        end
    endtask

    task test_token;
        model = predict(model, 8'h96, 5'b10000, 16'h0000, 64'h0, 1'b0);
        sb.push_back(model);
        // one-clock K glitch that must never be sampled
        cur_k = 1'b1;
        put_line(1'b0);
        @(posedge clk);
        #1;
        cur_k = 1'b0;
        put_line(1'b0);
        repeat (CPB) @(posedge clk);
        #1;
        send_field(64'h80, 8);
        send_field(64'h96, 8);
        send_field(64'h08, 4);
        // last CRC5 bit (0): register must update 7 clocks after the bit start
        put_line(1'b0);
        repeat (CPB - 2) @(posedge clk);
        #1;
        n_vec++;
        if (rcv_crc5 !== 5'h00) begin
            n_err++;
            $display("FAIL crc5_latency_early: got %h expected %h", rcv_crc5, 5'h00);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (rcv_crc5 !== 5'h10) begin
            n_err++;
            $display("FAIL crc5_latency_load: got %h expected %h", rcv_crc5, 5'h10);
        end
        @(posedge clk);
        #1;
        send_eop;
        exp_r = sb.pop_front();
        act = outs();
        n_vec++;
        if (act !== exp_r) begin
            n_err++;
            $display("FAIL token_packet: got %h expected %h", act, exp_r);
        end
    endtask

    task test_data;
        model = predict(model, 8'h3C, 5'h00, 16'hF0F0, 64'hFFFF0000FFFF0000, 1'b1);
        sb.push_back(model);
        send_field(64'h80, 8);
        send_field(64'h3C, 8);
        send_field(64'hF0F0, 16);
        send_field(64'hFFFF0000FFFF0000, 64);
        send_eop;
        exp_r = sb.pop_front();
        act = outs();
        n_vec++;
        if (act !== exp_r) begin
            n_err++;
            $display("FAIL data_packet: got %h expected %h", act, exp_r);
        end
    endtask

    task test_handshake;
        model = predict(model, 8'h2D, 5'h00, 16'h0000, 64'h0, 1'b0);
        sb.push_back(model);
        send_field(64'h80, 8);
        send_field(64'h2D, 8);
        send_eop;
        exp_r = sb.pop_front();
        act = outs();
        n_vec++;
        if (act !== exp_r) begin
            n_err++;
            $display("FAIL handshake_packet: got %h expected %h", act, exp_r);
        end
    endtask

    task test_abort;
        logic [63:0] d;
        d = 64'hA5A55A5AC3C33C3C;
        model = predict(model, 8'h3C, 5'h00, 16'h1234, d, 1'b0);
        sb.push_back(model);
        send_field(64'h80, 8);
        send_field(64'h3C, 8);
        send_field(64'h1234, 16);
        send_field(d >> 34, 30);
        send_eop;
        exp_r = sb.pop_front();
        act = outs();
        n_vec++;
        if (act !== exp_r) begin
            n_err++;
            $display("FAIL aborted_data: got %h expected %h", act, exp_r);
        end
        model = predict(model, 8'h5A, 5'h0B, 16'h0000, 64'h0, 1'b0);
        sb.push_back(model);
        send_field(64'h80, 8);
        send_field(64'h5A, 8);
        send_field(64'h0B, 5);
        send_eop;
        exp_r = sb.pop_front();
        act = outs();
        n_vec++;
        if (act !== exp_r) begin
            n_err++;
            $display("FAIL token_after_abort: got %h expected %h", act, exp_r);
        end
    endtask

    task test_bad_pid;
        model = predict(model, 8'h97, 5'h1F, 16'h0000, 64'h0, 1'b0);
        sb.push_back(model);
        send_field(64'h80, 8);
        send_field(64'h97, 8);
        send_field(64'h1F, 5);
        send_eop;
        exp_r = sb.pop_front();
        act = outs();
        n_vec++;
        if (act !== exp_r) begin
            n_err++;
            $display("FAIL bad_pid: got %h expected %h", act, exp_r);
        end
    endtask

    task test_reset_mid;
        send_field(64'h80, 8);
        send_field(64'h3C, 8);
        send_field(64'hBEEF, 16);
        send_field(64'h2AB, 10);
        #2;
        rst = 1'b1;
        #1;
        act = outs();
        n_vec++;
        if (act !== '0) begin
            n_err++;
            $display("FAIL reset_async: got %h expected %h", act, 101'h0);
        end
        cur_k = 1'b0;
        put_line(1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model = '0;
        sb.push_back(model);
        repeat (2 * CPB) @(posedge clk);
        #1;
        exp_r = sb.pop_front();
        act = outs();
        n_vec++;
        if (act !== exp_r) begin
            n_err++;
            $display("FAIL after_reset_idle: got %h expected %h", act, exp_r);
        end
        model = predict(model, 8'h2D, 5'h00, 16'h0000, 64'h0, 1'b0);
        sb.push_back(model);
        send_field(64'h80, 8);
        send_field(64'h2D, 8);
        send_eop;
        exp_r = sb.pop_front();
        act = outs();
        n_vec++;
        if (act !== exp_r) begin
            n_err++;
            $display("FAIL after_reset_handshake: got %h expected %h", act, exp_r);
        end
    endtask

    initial begin
        test_reset;
        test_token;
        test_data;
        test_handshake;
        test_abort;
        test_bad_pid;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
